multiplier_control: RTL and testbench

MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/multiplier_control.sv | 56 +++++
 tb/tb_multiplier_control.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared state encoding and default operand width for the
// shift-add multiplier controller.
package multiplier_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLRA,
        ADD,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/multiplier_control.sv
// multiplier_control: sequences one add/shift pair per multiplier bit,
// subtracting on the sign bit so A:B ends up holding the signed product.
module multiplier_control
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic clr_A,
    output logic ld_B,
    output logic ld_A,
    output logic fn,
    output logic shift_en,
    output logic done
);

    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic last;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Undefined encodings fall back to IDLE via the final branch.
    always_comb begin
        last     = cnt == LAST;
        state_nx = state == IDLE  ? (Run ? CLRA : IDLE) :
                   state == CLRA  ? ADD :
                   state == ADD   ? SHIFT :
                   state == SHIFT ? (last ? HOLD : ADD) :
                   (state == HOLD && Run) ? HOLD : IDLE;
        cnt_nx   = state == CLRA ? '0 :
                   (state == SHIFT && !last) ? cnt + 1'b1 : cnt;
        clr_A    = state == CLRA || (state == IDLE && ClearA_LoadB);
        ld_B     = state == IDLE && ClearA_LoadB;
        ld_A     = state == ADD && M;
        fn       = state == ADD && last;
        shift_en = state == SHIFT;
        done     = state == HOLD;
    end

endmodule

// File: tb/tb_multiplier_control.sv
// tb_multiplier_control: table-driven cycle checks of the controller plus
// directed sequences for reset, HOLD behaviour and full signed products.
module tb_multiplier_control;
    import multiplier_pkg::*;

    localparam int W = MULT_WIDTH;

    logic Clk = 1'b0, reset_n = 1'b0, Run = 1'b0, ClearA_LoadB = 1'b0, m_drv = 1'b0;
    logic M;
    logic clr_A, ld_B, ld_A, fn, shift_en, done;
    int checks = 0, fails = 0;

    logic dp = 1'b0;
    logic x;
    logic [W-1:0] a, b, s, sw;
    logic [W:0] sum;

    multiplier_control #(.WIDTH(W)) dut (
        .Clk(Clk), .reset_n(reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .clr_A(clr_A), .ld_B(ld_B), .ld_A(ld_A), .fn(fn), .shift_en(shift_en), .done(done)
    );

    always #5 Clk = ~Clk;

    // Reference datapath: X:A accumulator, B multiplier, S multiplicand.
    assign M   = dp ? b[0] : m_drv;
    assign sum = fn ? {a[W-1], a} - {s[W-1], s} : {a[W-1], a} + {s[W-1], s};

    always @(posedge Clk) begin
        if (clr_A) begin
            x <= 1'b0;
            a <= '0;
        end
        if (ld_B) b <= sw;
        if (ld_A) {x, a} <= sum;
        if (shift_en) {x, a, b} <= {x, x, a, b[W-1:1]};
    end

    typedef struct {
        logic run;
        logic clab;
        logic m;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [5:0] outs();
        return {clr_A, ld_B, ld_A, fn, shift_en, done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One whole multiply from IDLE back to IDLE; outputs are {clr_A,ld_B,ld_A,fn,shift_en,done}.
    task automatic add_run(input logic m, input logic clab);
        tbl.push_back('{1'b1, clab, m, {clab, clab, 4'b0000}});
        tbl.push_back('{1'b1, clab, m, 6'b100000});
        for (int i = 0; i < W; i++) begin
            tbl.push_back('{1'b1, clab, m, {2'b00, m, i == W - 1, 2'b00}});
            tbl.push_back('{1'b1, clab, m, 6'b000010});
        end
        tbl.push_back('{1'b0, clab, m, 6'b000001});
    endtask

    task automatic product(input logic [W-1:0] ms, input logic [W-1:0] mb,
                           input logic [2*W-1:0] exp, input string name);
        int cyc;
        dp = 1'b1;
        @(negedge Clk);
        sw = mb;
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        s = ms;
        Run = 1'b1;
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge Clk);
            cyc++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check(name, {16'd0, a, b}, {16'd0, exp});
        Run = 1'b0;
        @(negedge Clk);
        dp = 1'b0;
    endtask

    initial begin
        int nsh, nld, nfn, cyc;
        add_run(1'b1, 1'b0);
        add_run(1'b0, 1'b1);

        #1;
        check("reset_idle", {26'd0, outs()}, 32'h00);
        ClearA_LoadB = 1'b1;
        #1;
        check("reset_clab", {26'd0, outs()}, 32'h30);
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge Clk);
            Run = tbl[i].run;
            ClearA_LoadB = tbl[i].clab;
            m_drv = tbl[i].m;
            #1;
            check($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp});
        end
        ClearA_LoadB = 1'b0;

        // Asynchronous reset in the SHIFT state with cnt=3.
        @(negedge Clk);
        Run = 1'b1;
        m_drv = 1'b1;
        nsh = 0;
        cyc = 0;
        while (nsh < 4 && cyc < 40) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (shift_en) nsh++;
        end
        check("shift4_reached", nsh, 4);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_outs", {26'd0, outs()}, 32'h00);

        // Restart: edge k samples Run, done arrives 18 cycles later.
        @(negedge Clk);
        reset_n = 1'b1;
        nsh = 0;
        nld = 0;
        nfn = 0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (cyc == 1) check("restart_clra", {31'd0, clr_A}, 32'd1);
            nsh += shift_en;
            nld += ld_A;
            nfn += fn;
        end
        check("latency", cyc, 2 * W + 2);
        check("shift_count", nsh, W);
        check("lda_count", nld, W);
        check("fn_count", nfn, 1);

        // Run held through HOLD must not restart.
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            #1;
            check($sformatf("hold%0d", i), {26'd0, outs()}, 32'h01);
        end
        @(negedge Clk);
        Run = 1'b0;
        @(posedge Clk);
        #1;
        check("hold_to_idle", {26'd0, outs()}, 32'h00);
        Run = 1'b1;
        @(posedge Clk);
        #1;
        check("idle_to_clra", {26'd0, outs()}, 32'h20);

        @(negedge Clk);
        reset_n = 1'b0;
        Run = 1'b0;
        #2 reset_n = 1'b1;

        product(8'h07, 8'hFE, 16'hFFF2, "prod_7x-2");
        product(8'h80, 8'h80, 16'h4000, "prod_80x80");
        product(8'h05, 8'h03, 16'h000F, "prod_5x3");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
